// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding command sequencer in front of ALU_TOP.
// Define ALU_SEQ_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles.
module alu_cmd_sequencer #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_fun,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_fun,
  output logic             alu_enable,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_fun,
  output logic             rsp_error,
  output logic             busy,
  output logic [7:0]       done_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_fun;
  logic [WIDTH-1:0] r_rsp_data;
  logic [3:0]       r_rsp_fun;
  logic [7:0]       r_done_count;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wcnt;
  logic          r_rsp_error;
  logic          w_expire;

  // Last WAIT cycle: this one completes TIMEOUT_CYCLES waits.
  assign w_expire = (r_wcnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state      <= S_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_fun    <= '0;
      r_rsp_data   <= '0;
      r_rsp_fun    <= '0;
      r_done_count <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      r_wcnt       <= '0;
      r_rsp_error  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_alu_a   <= cmd_a;
            r_alu_b   <= cmd_b;
            r_alu_fun <= cmd_fun;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
          r_wcnt  <= '0;
`endif
        end
        S_WAIT: begin
          // A late result in the expiry cycle still wins.
          if (alu_out_valid) begin
            r_rsp_data  <= alu_out;
            r_rsp_fun   <= r_alu_fun;
            r_state     <= S_RESP;
`ifdef ALU_SEQ_TIMEOUT_EN
            r_rsp_error <= 1'b0;
`endif
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (w_expire) begin
            r_rsp_data  <= '0;
            r_rsp_fun   <= r_alu_fun;
            r_rsp_error <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_done_count <= r_done_count + 8'd1;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == S_IDLE);
  assign alu_enable = (r_state == S_ISSUE);
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_fun    = r_alu_fun;
  assign rsp_data   = r_rsp_data;
  assign rsp_fun    = r_rsp_fun;
  assign done_count = r_done_count;

`ifdef ALU_SEQ_TIMEOUT_EN
  assign rsp_error = r_rsp_error;
`else
  assign rsp_error = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer with a transaction model
// and a simple latency-programmable ALU stand-in.
module tb_alu_cmd_sequencer;
  localparam int W  = 16;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         RST = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_fun = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_fun;
  logic         alu_enable;
  logic [W-1:0] alu_out;
  logic         alu_out_valid;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_fun;
  logic         rsp_error;
  logic         busy;
  logic [7:0]   done_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_enable(alu_enable), .alu_out(alu_out),
    .alu_out_valid(alu_out_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_fun(rsp_fun),
    .rsp_error(rsp_error), .busy(busy),
    .done_count(done_count)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int en_cnt  = 0;
  bit chk_en  = 0;
  bit rnd_rdy = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (alu_enable) en_cnt++;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] alu_func(logic [3:0] f,
      logic [W-1:0] a, logic [W-1:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return ~(a & b);
      4'd7:    return ~(a | b);
      4'd8:    return a ^ b;
      default: return (a >> 1) ^ b ^ W'(f);
    endcase
  endfunction

  // ALU stand-in: result valid alu_lat cycles after the enable edge
  int           alu_lat   = 1;
  bit           alu_stall = 0;
  int           alu_cnt;
  logic [W-1:0] alu_res;

  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      alu_cnt       <= 0;
      alu_out_valid <= 1'b0;
      alu_out       <= '0;
      alu_res       <= '0;
    end else begin
      alu_out_valid <= 1'b0;
      alu_out       <= W'($urandom);
      if (alu_enable) begin
        alu_cnt <= alu_stall ? 0 : alu_lat;
        alu_res <= alu_func(alu_fun, alu_a, alu_b);
      end else if (alu_cnt == 1) begin
        alu_cnt       <= 0;
        alu_out_valid <= 1'b1;
        alu_out       <= alu_res;
      end else if (alu_cnt > 1) begin
        alu_cnt <= alu_cnt - 1;
      end
    end
  end

  // Transaction model: one command in flight, phases as flags
  bit           m_busy, m_issue, m_resp, m_err;
  int           m_wait;
  logic [W-1:0] m_a, m_b, m_data;
  logic [3:0]   m_f, m_rf;
  logic [7:0]   m_cnt;

  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      m_busy = 0; m_issue = 0; m_resp = 0; m_err = 0;
      m_wait = 0; m_a = '0; m_b = '0; m_data = '0;
      m_f = '0; m_rf = '0; m_cnt = '0;
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_resp = 0;
        m_busy = 0;
        m_cnt  = m_cnt + 8'd1;
      end
    end else if (m_issue) begin
      m_issue = 0;
      m_wait  = 0;
    end else if (m_busy) begin
      if (alu_out_valid) begin
        m_resp = 1; m_data = alu_out; m_rf = m_f; m_err = 0;
      end
`ifdef ALU_SEQ_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TO) begin
          m_resp = 1; m_data = '0; m_rf = m_f; m_err = 1;
        end
      end
`endif
    end else if (cmd_valid) begin
      m_busy = 1; m_issue = 1;
      m_a = cmd_a; m_b = cmd_b; m_f = cmd_fun;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("alu_enable", 32'(alu_enable), 32'(m_issue));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_fun", 32'(alu_fun), 32'(m_f));
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_fun", 32'(rsp_fun), 32'(m_rf));
      chk("rsp_error", 32'(rsp_error), 32'(m_err));
      chk("done_count", 32'(done_count), 32'(m_cnt));
    end
  end

  task automatic send(input logic [3:0] f, input logic [W-1:0] a,
                      input logic [W-1:0] b, output int acc);
    int k = 0;
    cmd_valid = 1'b1; cmd_fun = f; cmd_a = a; cmd_b = b;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: cmd_ready 0 expected 1");
    end
    acc = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output int fc, output logic [W-1:0] d,
                           output logic [3:0] f, output logic e);
    int  k = 0;
    bit  fin = 0;
    fc = -1; d = '0; f = '0; e = 1'b0;
    while (!fin) begin
      if (rsp_valid && fc < 0) fc = cyc;
      rsp_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        d = rsp_data; f = rsp_fun; e = rsp_error;
        @(negedge clk);
        fin = 1;
      end else if (k++ > 200) begin
        n_tests++; n_fail++;
        $display("FAIL resp_timeout: rsp_valid 0 expected 1");
        fin = 1;
      end else begin
        @(negedge clk);
      end
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           acc, fc, e0;
    logic [W-1:0] d;
    logic [3:0]   f, rf, fn;
    logic         e;
    logic [W-1:0] ra, rb;

    repeat (3) @(negedge clk);
    #2 RST = 1'b1;
    @(negedge clk);
    chk_en = 1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    chk("rst_done", 32'(done_count), 32'(0));

    // ADD, ALU latency 1
    #1 e0 = en_cnt;
    send(4'd0, 16'd10, 16'd5, acc);
    wait_resp(fc, d, f, e);
    chk("add_latency", 32'(fc - acc), 32'(3));
    chk("add_data", 32'(d), 32'(15));
    chk("add_fun", 32'(f), 32'(0));
    chk("add_err", 32'(e), 32'(0));
    #1;
    chk("add_en_pulses", 32'(en_cnt - e0), 32'(1));
    chk("add_done", 32'(done_count), 32'(1));

    // NOR with three cycles of backpressure
    rsp_ready = 1'b0;
    send(4'd7, 16'd10, 16'd5, acc);
    for (int k = 0; k < 50 && !rsp_valid; k++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_data", 32'(rsp_data), 32'(65520));
      chk("bp_cmd_ready", 32'(cmd_ready), 32'(0));
      @(negedge clk);
    end
    chk("bp_valid4", 32'(rsp_valid), 32'(1));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_released", 32'(rsp_valid), 32'(0));
    chk("bp_done", 32'(done_count), 32'(2));

    // MUL presented while busy is held off
    alu_lat = 4;
    send(4'd0, 16'd1, 16'd2, acc);
    cmd_valid = 1'b1; cmd_fun = 4'd2; cmd_a = 16'd10; cmd_b = 16'd5;
    repeat (2) @(negedge clk);
    chk("rej_alu_fun", 32'(alu_fun), 32'(0));
    chk("rej_alu_a", 32'(alu_a), 32'(1));
    chk("rej_cmd_ready", 32'(cmd_ready), 32'(0));
    wait_resp(fc, d, f, e);
    chk("rej_first", 32'(d), 32'(3));
    send(4'd2, 16'd10, 16'd5, acc);
    wait_resp(fc, d, f, e);
    chk("rej_mul", 32'(d), 32'(50));
    chk("rej_done", 32'(done_count), 32'(4));

    // Silent ALU
    alu_stall = 1;
    send(4'd1, 16'd7, 16'd3, acc);
`ifdef ALU_SEQ_TIMEOUT_EN
    wait_resp(fc, d, f, e);
    chk("to_latency", 32'(fc - acc), 32'(TO + 1));
    chk("to_err", 32'(e), 32'(1));
    chk("to_data", 32'(d), 32'(0));
    chk("to_fun", 32'(f), 32'(1));
    send(4'd5, 16'd3, 16'd3, acc);
    repeat (3) @(negedge clk);
`else
    for (int i = 0; i < 30; i++) begin
      chk("noto_busy", 32'(busy), 32'(1));
      @(negedge clk);
    end
`endif

    // Reset while in WAIT
    #2 RST = 1'b0;
    #1;
    chk("mr_alu_enable", 32'(alu_enable), 32'(0));
    chk("mr_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("mr_busy", 32'(busy), 32'(0));
    chk("mr_done", 32'(done_count), 32'(0));
    @(negedge clk);
    #2 RST = 1'b1;
    alu_stall = 0;
    alu_lat = 1;
    @(negedge clk);
    send(4'd0, 16'd100, 16'd23, acc);
    wait_resp(fc, d, f, e);
    chk("mr_next", 32'(d), 32'(123));
    chk("mr_next_done", 32'(done_count), 32'(1));

    // Random traffic; 256 completions since reset wrap the count
    rnd_rdy = 1;
    for (int i = 0; i < 255; i++) begin
      alu_lat = $urandom_range(1, 5);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      fn = 4'($urandom);
      ra = W'($urandom);
      rb = W'($urandom);
      send(fn, ra, rb, acc);
      wait_resp(fc, d, rf, e);
      chk("rnd_result", 32'(d), 32'(alu_func(fn, ra, rb)));
      chk("rnd_fun", 32'(rf), 32'(fn));
      chk("rnd_err", 32'(e), 32'(0));
      if (i == 253) chk("wrap_255", 32'(done_count), 32'(255));
    end
    chk("wrap_0", 32'(done_count), 32'(0));

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
